// File: rtl/vend_fsm_param.sv
// Parametrised coin-vending controller: accumulates coin credit, pulses coke_out at PRICE,
// then pays back any excess or cancelled credit as back-to-back one-unit change pulses.
module vend_fsm_param #(
    parameter int PRICE   = 3,
    parameter int COIN_HI = 2,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_valid,
    input  logic          coin_hi,
    input  logic          cancel,
    output logic          coke_out,
    output logic          change_out,
    output logic          coin_rej,
    output logic          busy,
    output logic [CW-1:0] credit
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_CHANGE = 2'd2
    } state_e;

    localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW:0] HI_W    = (CW+1)'(COIN_HI);
    localparam logic [CW:0] ONE_W   = (CW+1)'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          coke_q, coke_d;
    logic          change_q, change_d;
    logic          rej_q, rej_d;

    // One extra bit so credit + coin can be compared against PRICE without wrapping.
    logic [CW:0] sum;
    logic [CW:0] rem;

    assign sum = {1'b0, credit_q} + (coin_hi ? HI_W : ONE_W);
    assign rem = sum - PRICE_W;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        credit_d = credit_q;
        coke_d   = 1'b0;
        change_d = 1'b0;
        rej_d    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (coin_valid) begin
                    if (sum >= PRICE_W) begin
                        // Vend wins over a simultaneous cancel; only the excess is refunded.
                        coke_d   = 1'b1;
                        credit_d = rem[CW-1:0];
                        state_d  = (rem == '0) ? ST_IDLE : ST_CHANGE;
                    end else begin
                        credit_d = sum[CW-1:0];
                        state_d  = cancel ? ST_CHANGE : ST_ACCUM;
                    end
                end else if (cancel && (credit_q != '0)) begin
                    state_d = ST_CHANGE;
                end
            end

            ST_CHANGE: begin
                change_d = 1'b1;
                rej_d    = coin_valid;
                credit_d = credit_q - CW'(1);
                if (credit_q <= CW'(1)) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                credit_d = '0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            coke_q   <= 1'b0;
            change_q <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            coke_q   <= coke_d;
            change_q <= change_d;
            rej_q    <= rej_d;
        end
    end

    assign coke_out   = coke_q;
    assign change_out = change_q;
    assign coin_rej   = rej_q;
    assign busy       = (state_q == ST_CHANGE);
    assign credit     = credit_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: a default instance and a PRICE=5/COIN_HI=4 instance
// run side by side against a credit/refund reference model.
module tb_vend_fsm_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] coin_valid, coin_hi, cancel;
    logic [1:0] coke_out, change_out, coin_rej, busy;
    logic [3:0] credit0, credit1;
    logic [1:0][3:0] dut_credit;

    assign dut_credit = {credit1, credit0};

    always #5 clk = ~clk;

    vend_fsm_param #(.PRICE(3), .COIN_HI(2), .CW(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid[0]), .coin_hi(coin_hi[0]), .cancel(cancel[0]),
        .coke_out(coke_out[0]), .change_out(change_out[0]), .coin_rej(coin_rej[0]),
        .busy(busy[0]), .credit(credit0)
    );

    vend_fsm_param #(.PRICE(5), .COIN_HI(4), .CW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid[1]), .coin_hi(coin_hi[1]), .cancel(cancel[1]),
        .coke_out(coke_out[1]), .change_out(change_out[1]), .coin_rej(coin_rej[1]),
        .busy(busy[1]), .credit(credit1)
    );

    typedef struct packed {
        logic [1:0]      coke;
        logic [1:0]      change;
        logic [1:0]      rej;
        logic [1:0]      busy;
        logic [1:0][3:0] credit;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_coke[2], cnt_change[2], cnt_rej[2];

    // Reference model: credit held, and whether that credit is currently being paid back.
    int m_price[2] = '{3, 5};
    int m_hi[2]    = '{2, 4};
    int m_credit[2];
    bit m_refund[2];

    logic [1:0] r_cv, r_chi, r_cn;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic model_step(input int i, input bit cv, input bit chi, input bit cn, inout exp_t e);
        int sum;
        e.coke[i]   = 1'b0;
        e.change[i] = 1'b0;
        e.rej[i]    = 1'b0;
        if (m_refund[i]) begin
            e.change[i] = 1'b1;
            e.rej[i]    = cv;
            m_credit[i] = m_credit[i] - 1;
            if (m_credit[i] == 0) m_refund[i] = 1'b0;
        end else if (cv) begin
            sum = m_credit[i] + (chi ? m_hi[i] : 1);
            if (sum >= m_price[i]) begin
                e.coke[i]   = 1'b1;
                m_credit[i] = sum - m_price[i];
                m_refund[i] = (m_credit[i] > 0);
            end else begin
                m_credit[i] = sum;
                m_refund[i] = cn;
            end
        end else if (cn && m_credit[i] > 0) begin
            m_refund[i] = 1'b1;
        end
        e.busy[i]   = m_refund[i];
        e.credit[i] = 4'(m_credit[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_credit[i] = 0;
            m_refund[i] = 1'b0;
        end
    endtask

    task automatic step(input logic [1:0] cv, input logic [1:0] chi, input logic [1:0] cn);
        exp_t e;
        @(negedge clk);
        coin_valid = cv;
        coin_hi    = chi;
        cancel     = cn;
        e = '0;
        for (int i = 0; i < 2; i++) model_step(i, cv[i], chi[i], cn[i], e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 2'b00, 2'b00);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            cnt_coke[i]   = 0;
            cnt_change[i] = 0;
            cnt_rej[i]    = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_coke"},   i, coke_out[i],   0);
            check({tag, "_change"}, i, change_out[i], 0);
            check({tag, "_rej"},    i, coin_rej[i],   0);
            check({tag, "_busy"},   i, busy[i],       0);
            check({tag, "_credit"}, i, dut_credit[i], 0);
        end
    endtask

    // Monitor: outputs settle after each rising edge; compare against the oldest expectation.
    initial begin : monitor
        exp_t mon_e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    check("coke_out",   i, coke_out[i],   mon_e.coke[i]);
                    check("change_out", i, change_out[i], mon_e.change[i]);
                    check("coin_rej",   i, coin_rej[i],   mon_e.rej[i]);
                    check("busy",       i, busy[i],       mon_e.busy[i]);
                    check("credit",     i, dut_credit[i], mon_e.credit[i]);
                    cnt_coke[i]   += int'(coke_out[i]);
                    cnt_change[i] += int'(change_out[i]);
                    cnt_rej[i]    += int'(coin_rej[i]);
                end
            end
        end
    end

    initial begin : driver
        rst_n      = 1'b0;
        coin_valid = 2'b00;
        coin_hi    = 2'b00;
        cancel     = 2'b00;
        model_reset();
        clear_counts();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three single coins on the default instance vend with no change.
        clear_counts();
        repeat (3) step(2'b01, 2'b00, 2'b00);
        idle(3);
        check("t1_coke_count",   0, cnt_coke[0],   1);
        check("t1_change_count", 0, cnt_change[0], 0);

        // Two large coins: vend, then one unit of change.
        clear_counts();
        repeat (2) step(2'b01, 2'b01, 2'b00);
        idle(4);
        check("t2_coke_count",   0, cnt_coke[0],   1);
        check("t2_change_count", 0, cnt_change[0], 1);

        // Large coin then cancel: two units refunded; cancel while idle does nothing.
        clear_counts();
        step(2'b01, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        idle(4);
        step(2'b00, 2'b00, 2'b01);
        idle(2);
        check("t3_coke_count",   0, cnt_coke[0],   0);
        check("t3_change_count", 0, cnt_change[0], 2);

        // Coin plus cancel below price refunds the new coin too; at price the vend wins.
        clear_counts();
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b01);
        idle(4);
        check("t4a_change_count", 0, cnt_change[0], 2);
        clear_counts();
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b00);
        step(2'b01, 2'b00, 2'b01);
        idle(3);
        check("t4b_coke_count",   0, cnt_coke[0],   1);
        check("t4b_change_count", 0, cnt_change[0], 0);

        // PRICE=5/COIN_HI=4 instance: 8 units -> vend + 3 change, coin during refund rejected.
        clear_counts();
        repeat (2) step(2'b10, 2'b10, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        idle(5);
        check("t5_coke_count",   1, cnt_coke[1],   1);
        check("t5_change_count", 1, cnt_change[1], 3);
        check("t5_rej_count",    1, cnt_rej[1],    1);

        // Asynchronous reset while the default instance is refunding 2 units.
        step(2'b01, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b01);
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        coin_valid = 2'b00;
        coin_hi    = 2'b00;
        cancel     = 2'b00;
        #1;
        check_all_zero("async_rst");
        model_reset();
        clear_counts();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("t6_change_after_rst", 0, cnt_change[0], 0);

        // Randomised traffic on both instances.
        for (int k = 0; k < 1500; k++) begin
            for (int j = 0; j < 2; j++) begin
                r_cv[j]  = ($urandom_range(0, 99) < 55);
                r_chi[j] = 1'($urandom_range(0, 1));
                r_cn[j]  = ($urandom_range(0, 99) < 12);
            end
            step(r_cv, r_chi, r_cn);
        end
        idle(12);

        @(posedge clk);
        #2;
        check("queue_drained", 0, exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
